// File: rtl/vga_axil_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_axil_pkg
// Description : Shared AXI-Lite bus types for the VGA controller: address and
//               data types plus the response code enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_axil_pkg;

    typedef logic [31:0] axil_addr_t;
    typedef logic [31:0] axil_data_t;

    typedef enum logic [1:0] {
        AXIL_RESP_OKAY   = 2'b00,
        AXIL_RESP_EXOKAY = 2'b01,
        AXIL_RESP_SLVERR = 2'b10,
        AXIL_RESP_DECERR = 2'b11
    } axil_resp_e;

endpackage : vga_axil_pkg
`default_nettype wire

// File: rtl/vga_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_regs_pkg
// Description : Register map, control-register layout, STATUS field positions
//               and handshake FSM state encodings for vga_axil_regs.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_regs_pkg;

    // Byte offsets; only address bits [4:2] take part in decoding.
    localparam logic [4:0] VGA_REG_CTRL_OFFS     = 5'h00;
    localparam logic [4:0] VGA_REG_FB_BASE_OFFS  = 5'h04;
    localparam logic [4:0] VGA_REG_STATUS_OFFS   = 5'h08;
    localparam logic [4:0] VGA_REG_IRQ_EN_OFFS   = 5'h0C;
    localparam logic [4:0] VGA_REG_IRQ_STAT_OFFS = 5'h10;

    // STATUS = {frame_cnt[15:0], 15'b0, vsync}
    localparam int unsigned VGA_STATUS_VSYNC_BIT = 0;
    localparam int unsigned VGA_STATUS_FCNT_LSB  = 16;
    localparam int unsigned VGA_STATUS_FCNT_W    = 16;

    // CTRL[1] = test_pattern, CTRL[0] = enable
    typedef struct packed {
        logic test_pattern;
        logic enable;
    } vga_ctrl_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ACK  = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ACK  = 2'd1,
        R_RESP = 2'd2
    } rd_state_e;

endpackage : vga_regs_pkg
`default_nettype wire

// File: rtl/vga_axil_regs_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : vga_edge_det
// Description : Rising-edge detector. The previous input level is held in a
//               flop; rise_o is high during the first cycle the input is seen
//               high after being low.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_edge_det (
    input  logic clk,
    input  logic arst_n,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    // Remember last cycle's level for the compare.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule : vga_edge_det
`default_nettype wire

// File: rtl/vga_axil_regs.sv
`default_nettype none
// ============================================================================
// Module      : vga_axil_regs
// Description : AXI-Lite slave register file for the VGA controller. Holds
//               CTRL, FB_BASE, a read-only STATUS word with a vsync frame
//               counter and, when VGA_AXIL_REGS_IRQ_EN is defined, an IRQ
//               enable / W1C status pair driving a level interrupt.
//               Write and read paths are independent three-state FSMs
//               (IDLE -> ACK -> RESP) with registered handshake outputs.
// Build macro : VGA_AXIL_REGS_IRQ_EN (undefined: 0x0C/0x10 return SLVERR and
//               irq_o is tied low)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axil_regs
    import vga_regs_pkg::*;
#(
    parameter type axil_addr_t = vga_axil_pkg::axil_addr_t,
    parameter type axil_data_t = vga_axil_pkg::axil_data_t
) (
    input  logic                             clk,
    input  logic                             arst_n,
    // AW channel
    input  axil_addr_t                       awaddr,
    input  logic                             awvalid,
    output logic                             awready,
    // W channel
    input  axil_data_t                       wdata,
    input  logic [$bits(axil_data_t)/8-1:0]  wstrb,
    input  logic                             wvalid,
    output logic                             wready,
    // B channel
    output logic [1:0]                       bresp,
    output logic                             bvalid,
    input  logic                             bready,
    // AR channel
    input  axil_addr_t                       araddr,
    input  logic                             arvalid,
    output logic                             arready,
    // R channel
    output logic [31:0]                      rdata,
    output logic [1:0]                       rresp,
    output logic                             rvalid,
    input  logic                             rready,
    // VGA side
    input  logic                             vsync_i,
    output logic                             ctrl_enable_o,
    output logic                             ctrl_test_pattern_o,
    output logic [31:0]                      fb_base_o,
    output logic                             irq_o
);

    generate
        if ($bits(axil_data_t) != 32) begin : g_data_w_chk
            $error("vga_axil_regs: axil_data_t must be 32 bits wide");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------------
    wr_state_e                wr_state_q;
    rd_state_e                rd_state_q;

    vga_ctrl_t                ctrl_q,      ctrl_d;
    logic [31:0]              fb_base_q,   fb_base_d;
    logic [15:0]              frame_cnt_q, frame_cnt_d;

    logic                     wr_fire;
    vga_axil_pkg::axil_resp_e wr_resp;
    logic [31:0]              rd_data;
    vga_axil_pkg::axil_resp_e rd_resp;
    logic                     vsync_rise;

`ifdef VGA_AXIL_REGS_IRQ_EN
    logic                     irq_en_q,   irq_en_d;
    logic                     irq_stat_q, irq_stat_d;
`endif

    // Address bits outside [4:2] and the byte strobes carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{wstrb, awaddr, araddr};

    // ------------------------------------------------------------------------
    // vsync edge: shared by the frame counter and the IRQ set path
    // ------------------------------------------------------------------------
    vga_edge_det u_vsync_edge (
        .clk    (clk),
        .arst_n (arst_n),
        .sig_i  (vsync_i),
        .rise_o (vsync_rise)
    );

    // ------------------------------------------------------------------------
    // Write decode and register next-state
    // ------------------------------------------------------------------------
    assign wr_fire = (wr_state_q == W_ACK);

    // Decode the write address, produce the response and next register values.
    always_comb begin
        ctrl_d    = ctrl_q;
        fb_base_d = fb_base_q;
        wr_resp   = vga_axil_pkg::AXIL_RESP_SLVERR;
`ifdef VGA_AXIL_REGS_IRQ_EN
        irq_en_d   = irq_en_q;
        irq_stat_d = irq_stat_q;
`endif
        case ({awaddr[4:2], 2'b00})
            VGA_REG_CTRL_OFFS: begin
                wr_resp = vga_axil_pkg::AXIL_RESP_OKAY;
                if (wr_fire) begin
                    ctrl_d = vga_ctrl_t'(wdata[1:0]);
                end
            end
            VGA_REG_FB_BASE_OFFS: begin
                wr_resp = vga_axil_pkg::AXIL_RESP_OKAY;
                if (wr_fire) begin
                    fb_base_d = wdata;
                end
            end
            VGA_REG_STATUS_OFFS: begin
                // Read-only: accepted and ignored.
                wr_resp = vga_axil_pkg::AXIL_RESP_OKAY;
            end
`ifdef VGA_AXIL_REGS_IRQ_EN
            VGA_REG_IRQ_EN_OFFS: begin
                wr_resp = vga_axil_pkg::AXIL_RESP_OKAY;
                if (wr_fire) begin
                    irq_en_d = wdata[0];
                end
            end
            VGA_REG_IRQ_STAT_OFFS: begin
                wr_resp = vga_axil_pkg::AXIL_RESP_OKAY;
                if (wr_fire && wdata[0]) begin
                    irq_stat_d = 1'b0;
                end
            end
`endif
            default: begin
                wr_resp = vga_axil_pkg::AXIL_RESP_SLVERR;
            end
        endcase
`ifdef VGA_AXIL_REGS_IRQ_EN
        // Applied after the W1C so a coincident vsync edge wins.
        if (vsync_rise) begin
            irq_stat_d = 1'b1;
        end
`endif
        frame_cnt_d = frame_cnt_q + {15'b0, vsync_rise};
    end

    // Register file storage.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ctrl_q      <= '0;
            fb_base_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            fb_base_q   <= fb_base_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

`ifdef VGA_AXIL_REGS_IRQ_EN
    // Interrupt enable and sticky status flops.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            irq_en_q   <= 1'b0;
            irq_stat_q <= 1'b0;
        end else begin
            irq_en_q   <= irq_en_d;
            irq_stat_q <= irq_stat_d;
        end
    end

    assign irq_o = irq_stat_q & irq_en_q;
`else
    assign irq_o = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Write handshake FSM
    // ------------------------------------------------------------------------
    // AW and W are accepted together; ready pulses for one cycle, then B waits.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_state_q <= W_IDLE;
            awready    <= 1'b0;
            wready     <= 1'b0;
            bvalid     <= 1'b0;
            bresp      <= 2'b00;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (awvalid && wvalid) begin
                        wr_state_q <= W_ACK;
                        awready    <= 1'b1;
                        wready     <= 1'b1;
                    end
                end
                W_ACK: begin
                    wr_state_q <= W_RESP;
                    awready    <= 1'b0;
                    wready     <= 1'b0;
                    bvalid     <= 1'b1;
                    bresp      <= wr_resp;
                end
                W_RESP: begin
                    if (bready) begin
                        wr_state_q <= W_IDLE;
                        bvalid     <= 1'b0;
                    end
                end
                default: begin
                    wr_state_q <= W_IDLE;
                    awready    <= 1'b0;
                    wready     <= 1'b0;
                    bvalid     <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Read decode
    // ------------------------------------------------------------------------
    // Select the read word and response for the current AR address.
    always_comb begin
        rd_data = '0;
        rd_resp = vga_axil_pkg::AXIL_RESP_SLVERR;
        case ({araddr[4:2], 2'b00})
            VGA_REG_CTRL_OFFS: begin
                rd_data = {30'b0, ctrl_q};
                rd_resp = vga_axil_pkg::AXIL_RESP_OKAY;
            end
            VGA_REG_FB_BASE_OFFS: begin
                rd_data = fb_base_q;
                rd_resp = vga_axil_pkg::AXIL_RESP_OKAY;
            end
            VGA_REG_STATUS_OFFS: begin
                rd_data[VGA_STATUS_FCNT_LSB +: VGA_STATUS_FCNT_W] = frame_cnt_q;
                rd_data[VGA_STATUS_VSYNC_BIT]                     = vsync_i;
                rd_resp = vga_axil_pkg::AXIL_RESP_OKAY;
            end
`ifdef VGA_AXIL_REGS_IRQ_EN
            VGA_REG_IRQ_EN_OFFS: begin
                rd_data = {31'b0, irq_en_q};
                rd_resp = vga_axil_pkg::AXIL_RESP_OKAY;
            end
            VGA_REG_IRQ_STAT_OFFS: begin
                rd_data = {31'b0, irq_stat_q};
                rd_resp = vga_axil_pkg::AXIL_RESP_OKAY;
            end
`endif
            default: begin
                rd_data = '0;
                rd_resp = vga_axil_pkg::AXIL_RESP_SLVERR;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Read handshake FSM
    // ------------------------------------------------------------------------
    // AR ready pulses for one cycle; data is captured then held until rready.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_state_q <= R_IDLE;
            arready    <= 1'b0;
            rvalid     <= 1'b0;
            rdata      <= '0;
            rresp      <= 2'b00;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (arvalid) begin
                        rd_state_q <= R_ACK;
                        arready    <= 1'b1;
                    end
                end
                R_ACK: begin
                    rd_state_q <= R_RESP;
                    arready    <= 1'b0;
                    rvalid     <= 1'b1;
                    rdata      <= rd_data;
                    rresp      <= rd_resp;
                end
                R_RESP: begin
                    if (rready) begin
                        rd_state_q <= R_IDLE;
                        rvalid     <= 1'b0;
                    end
                end
                default: begin
                    rd_state_q <= R_IDLE;
                    arready    <= 1'b0;
                    rvalid     <= 1'b0;
                end
            endcase
        end
    end

    assign ctrl_enable_o       = ctrl_q.enable;
    assign ctrl_test_pattern_o = ctrl_q.test_pattern;
    assign fb_base_o           = fb_base_q;

endmodule : vga_axil_regs
`default_nettype wire

// File: tb/tb_vga_axil_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_axil_regs
// Description : Self-checking bench for vga_axil_regs. Directed scenarios
//               followed by random register traffic, compared against a
//               register-map level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_axil_regs;

`ifdef VGA_AXIL_REGS_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready, vsync_i;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, fb_base_o;
    logic        ctrl_enable_o, ctrl_test_pattern_o, irq_o;

    int checks = 0;
    int errors = 0;

    // Reference model state (register-map view)
    logic [1:0]  m_ctrl;
    logic [31:0] m_fb;
    logic        m_en, m_stat, m_vs;
    logic [15:0] m_frames;

    always #5 clk = ~clk;

    vga_axil_regs dut (
        .clk                 (clk),
        .arst_n              (arst_n),
        .awaddr              (awaddr),
        .awvalid             (awvalid),
        .awready             (awready),
        .wdata               (wdata),
        .wstrb               (wstrb),
        .wvalid              (wvalid),
        .wready              (wready),
        .bresp               (bresp),
        .bvalid              (bvalid),
        .bready              (bready),
        .araddr              (araddr),
        .arvalid             (arvalid),
        .arready             (arready),
        .rdata               (rdata),
        .rresp               (rresp),
        .rvalid              (rvalid),
        .rready              (rready),
        .vsync_i             (vsync_i),
        .ctrl_enable_o       (ctrl_enable_o),
        .ctrl_test_pattern_o (ctrl_test_pattern_o),
        .fb_base_o           (fb_base_o),
        .irq_o               (irq_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_ctrl = 2'b00; m_fb = 32'h0; m_en = 1'b0; m_stat = 1'b0; m_frames = 16'h0;
    endfunction

    function automatic void model_edge();
        m_frames = m_frames + 16'd1;
        if (IRQ) m_stat = 1'b1;
    endfunction

    function automatic logic [1:0] model_resp(input logic [31:0] addr);
        int idx = int'(addr[4:2]);
        if (idx <= 2) return OKAY;
        if (idx == 3 || idx == 4) return IRQ ? OKAY : SLVERR;
        return SLVERR;
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [31:0] data);
        case (int'(addr[4:2]))
            0: m_ctrl = data[1:0];
            1: m_fb   = data;
            3: if (IRQ) m_en = data[0];
            4: if (IRQ && data[0]) m_stat = 1'b0;
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        case (int'(addr[4:2]))
            0: return {30'b0, m_ctrl};
            1: return m_fb;
            2: return {m_frames, 15'b0, m_vs};
            3: return IRQ ? {31'b0, m_en} : 32'h0;
            4: return IRQ ? {31'b0, m_stat} : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk_outputs(input string tag);
        chk({tag, "_en"},   {31'b0, ctrl_enable_o},       {31'b0, m_ctrl[0]});
        chk({tag, "_tp"},   {31'b0, ctrl_test_pattern_o}, {31'b0, m_ctrl[1]});
        chk({tag, "_fb"},   fb_base_o, m_fb);
        chk({tag, "_irq"},  {31'b0, irq_o}, {31'b0, m_stat & m_en});
    endtask

    // One write transaction; AW may lead W by aw_lead cycles. With vs_at_ack,
    // vsync rises during the ack cycle so its edge lands with the register update.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input int aw_lead, input bit vs_at_ack, input string tag);
        int polls;
        @(negedge clk);
        awaddr  = addr;
        wdata   = data;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        for (int k = 0; k < aw_lead; k++) begin
            @(negedge clk);
            chk({tag, "_noready"}, {30'b0, awready, wready}, 32'h0);
        end
        wvalid = 1'b1;
        polls  = 0;
        do begin
            @(negedge clk);
            polls++;
        end while (!awready && polls < 20);
        chk({tag, "_aw_lat"}, 32'(polls), 32'd1);
        chk({tag, "_wready"}, {31'b0, wready}, 32'd1);
        chk_outputs({tag, "_pre"});
        model_write(addr, data);
        if (vs_at_ack) begin
            vsync_i = 1'b1;
            m_vs    = 1'b1;
            model_edge();
        end
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk({tag, "_bvalid"}, {31'b0, bvalid}, 32'd1);
        chk({tag, "_bresp"}, {30'b0, bresp}, {30'b0, model_resp(addr)});
        chk({tag, "_rdy_in_resp"}, {30'b0, awready, wready}, 32'h0);
        chk_outputs({tag, "_post"});
    endtask

    task automatic axi_read(input logic [31:0] addr, input string tag);
        int polls;
        @(negedge clk);
        araddr  = addr;
        arvalid = 1'b1;
        polls   = 0;
        do begin
            @(negedge clk);
            polls++;
        end while (!arready && polls < 20);
        chk({tag, "_ar_lat"}, 32'(polls), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        chk({tag, "_rvalid"}, {31'b0, rvalid}, 32'd1);
        chk({tag, "_ar_in_resp"}, {31'b0, arready}, 32'h0);
        chk({tag, "_rdata"}, rdata, model_read(addr));
        chk({tag, "_rresp"}, {30'b0, rresp}, {30'b0, model_resp(addr)});
    endtask

    task automatic vsync_pulse();
        @(negedge clk); vsync_i = 1'b1; m_vs = 1'b1; model_edge();
        @(negedge clk);
        @(negedge clk); vsync_i = 1'b0; m_vs = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        logic [2:0]  idx;
        arst_n = 1'b0;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1; vsync_i = 1'b0; m_vs = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_ready", {29'b0, awready, wready, arready}, 32'h0);
        chk("rst_valid", {30'b0, bvalid, rvalid}, 32'h0);
        chk("rst_resp",  {28'b0, bresp, rresp}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk_outputs("rst");
        arst_n = 1'b1;
        @(negedge clk);

        // CTRL write / readback
        axi_write(32'h0, 32'h0000_0003, 0, 1'b0, "ctrl_wr");
        chk("ctrl_both", {30'b0, ctrl_test_pattern_o, ctrl_enable_o}, 32'h3);
        axi_read(32'h0, "ctrl_rd");
        chk("ctrl_rd_lit", rdata, 32'h0000_0003);

        // FB_BASE with AW leading W
        axi_write(32'h4, 32'hDEAD_BEEF, 3, 1'b0, "fb_wr");
        chk("fb_lit", fb_base_o, 32'hDEAD_BEEF);
        axi_read(32'h4, "fb_rd");

        // Frame counter: five rising edges, last one held high
        repeat (4) vsync_pulse();
        @(negedge clk); vsync_i = 1'b1; m_vs = 1'b1; model_edge();
        repeat (2) @(negedge clk);
        axi_read(32'h8, "stat_rd");
        chk("stat_lit", rdata, 32'h0005_0001);
        axi_write(32'h8, 32'hFFFF_FFFF, 0, 1'b0, "stat_wr");
        axi_read(32'h8, "stat_rd2");
        @(negedge clk); vsync_i = 1'b0; m_vs = 1'b0;

        // Unmapped offset
        axi_read(32'h1C, "unm_rd");
        axi_write(32'h1C, 32'hFFFF_FFFF, 0, 1'b0, "unm_wr");
        axi_read(32'h0, "unm_ctrl_rd");
        axi_read(32'h4, "unm_fb_rd");

`ifdef VGA_AXIL_REGS_IRQ_EN
        // IRQ: clear leftovers, enable, edge sets, coincident clear loses
        axi_write(32'h10, 32'h1, 0, 1'b0, "irq_clr0");
        axi_write(32'h0C, 32'h1, 0, 1'b0, "irq_en");
        chk("irq_idle", {31'b0, irq_o}, 32'h0);
        vsync_pulse();
        chk("irq_set", {31'b0, irq_o}, 32'h1);
        axi_write(32'h10, 32'h1, 0, 1'b1, "irq_race");
        chk("irq_race_hold", {31'b0, irq_o}, 32'h1);
        @(negedge clk); vsync_i = 1'b0; m_vs = 1'b0;
        axi_write(32'h10, 32'h1, 0, 1'b0, "irq_clr");
        chk("irq_cleared", {31'b0, irq_o}, 32'h0);
        axi_read(32'h10, "irq_stat_rd");
`else
        axi_read(32'h0C, "noirq_en_rd");
        axi_write(32'h10, 32'h1, 0, 1'b0, "noirq_stat_wr");
`endif

        // Random traffic against the model
        for (int i = 0; i < 48; i++) begin
            r   = $urandom;
            idx = 3'($urandom_range(0, 7));
            a   = {r[31:5], idx, r[1:0]};
            case ($urandom_range(0, 2))
                0: axi_write(a, $urandom, int'($urandom_range(0, 2)), 1'b0, "rnd_wr");
                1: axi_read(a, "rnd_rd");
                default: begin
                    vsync_pulse();
                    chk_outputs("rnd_vs");
                end
            endcase
        end
        axi_read(32'h8, "rnd_stat_final");

        // Reset while a write response is pending
        @(negedge clk);
        bready  = 1'b0;
        awaddr  = 32'h0;
        wdata   = 32'h2;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        begin
            int polls = 0;
            do begin
                @(negedge clk);
                polls++;
            end while (!awready && polls < 20);
            chk("mid_aw_lat", 32'(polls), 32'd1);
        end
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk("mid_bvalid", {31'b0, bvalid}, 32'd1);
        #2 arst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_bvalid", {31'b0, bvalid}, 32'h0);
        chk("mid_rst_bresp", {30'b0, bresp}, 32'h0);
        chk_outputs("mid_rst");
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        bready = 1'b1;
        axi_read(32'h0, "post_rst_ctrl");
        axi_write(32'h4, 32'h1234_5678, 0, 1'b0, "post_rst_wr");
        axi_read(32'h4, "post_rst_rd");

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_vga_axil_regs
`default_nettype wire
